pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the IF/ID stall and flush inputs, PC write enable, ID/EX bubble and the EX/MEM and MEM/WB freeze controls. It resolves load-use hazards, taken branches/jumps resolved in ID, and multi-cycle data-memory waits. It also keeps saturating stall and flush performance counters and a sticky memory-timeout error.

---
 rtl/pipeline_ctrl_pkg.sv | 12 +
 rtl/load_use_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller and its helpers.
package pipeline_ctrl_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the ID instruction needs a value the EX load
// has not produced yet. Register 0 never creates a dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);

  assign lu_o = ex_memread_i && (ex_rt_i != '0) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, ID branch
// flushes, data-memory freezes with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             hazard_IF_ID_o,
  output logic             flush_IF_ID_o,
  output logic             bubble_ID_EX_o,
  output logic             stall_ID_EX_o,
  output logic             stall_EX_MEM_o,
  output logic             bubble_MEM_WB_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o,
  output logic [1:0]       dbg_state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              err_set;
  logic              lu;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .lu_o         (lu)
  );

  assign dbg_state = state;

  always_comb begin
    next_state      = state;
    wait_cnt_next   = wait_cnt;
    err_set         = 1'b0;
    pc_write_o      = 1'b1;
    hazard_IF_ID_o  = 1'b0;
    flush_IF_ID_o   = 1'b0;
    bubble_ID_EX_o  = 1'b0;
    stall_ID_EX_o   = 1'b0;
    stall_EX_MEM_o  = 1'b0;
    bubble_MEM_WB_o = 1'b0;

    if (rst_i) begin
      pc_write_o      = 1'b0;
      flush_IF_ID_o   = 1'b1;
      bubble_ID_EX_o  = 1'b1;
      bubble_MEM_WB_o = 1'b1;
      next_state      = RUN;
      wait_cnt_next   = '0;
    end else if (state == HALT || dmem_busy_i) begin
      // Freeze: the whole front of the pipe holds while MEM/WB writes nothing.
      pc_write_o      = 1'b0;
      hazard_IF_ID_o  = 1'b1;
      stall_ID_EX_o   = 1'b1;
      stall_EX_MEM_o  = 1'b1;
      bubble_MEM_WB_o = 1'b1;
      if (state == HALT) begin
        next_state = HALT;
      end else if (state == MEM_WAIT && wait_cnt >= TIMEOUT_V) begin
        next_state = HALT;
        err_set    = 1'b1;
      end else begin
        next_state    = MEM_WAIT;
        wait_cnt_next = wait_cnt + 1'b1;
      end
    end else begin
      next_state    = RUN;
      wait_cnt_next = '0;
      // A stall wins over a branch: the branch re-resolves once the load lands.
      if (lu) begin
        pc_write_o     = 1'b0;
        hazard_IF_ID_o = 1'b1;
        bubble_ID_EX_o = 1'b1;
      end else if (branch_taken_i) begin
        flush_IF_ID_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      mem_err_o   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (err_set) mem_err_o <= 1'b1;
      if (!pc_write_o && stall_cnt_o != {CNT_W{1'b1}}) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_IF_ID_o && flush_cnt_o != {CNT_W{1'b1}}) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance plus a small one
// (CNT_W=3, MEM_TIMEOUT=4) sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken, dmem_busy;

  logic        pc_write, hz, fl, bie, sie, sem, bmw, mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  st;
  logic        pc_write_s, hz_s, fl_s, bie_s, sie_s, sem_s, bmw_s, mem_err_s;
  logic [2:0]  stall_cnt_s, flush_cnt_s;
  logic [1:0]  st_s;

  int checks = 0;
  int failures = 0;

  // Control vector order: pc_write, hazard_IF_ID, flush_IF_ID, bubble_ID_EX,
  // stall_ID_EX, stall_EX_MEM, bubble_MEM_WB.
  localparam logic [6:0] C_RESET  = 7'b0011001;
  localparam logic [6:0] C_IDLE   = 7'b1000000;
  localparam logic [6:0] C_LU     = 7'b0101000;
  localparam logic [6:0] C_BRANCH = 7'b1010000;
  localparam logic [6:0] C_FREEZE = 7'b0100111;

  wire [6:0] ctl   = {pc_write, hz, fl, bie, sie, sem, bmw};
  wire [6:0] ctl_s = {pc_write_s, hz_s, fl_s, bie_s, sie_s, sem_s, bmw_s};

  pipeline_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken),
    .dmem_busy_i(dmem_busy), .pc_write_o(pc_write), .hazard_IF_ID_o(hz),
    .flush_IF_ID_o(fl), .bubble_ID_EX_o(bie), .stall_ID_EX_o(sie), .stall_EX_MEM_o(sem),
    .bubble_MEM_WB_o(bmw), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
    .mem_err_o(mem_err), .dbg_state(st)
  );

  pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken),
    .dmem_busy_i(dmem_busy), .pc_write_o(pc_write_s), .hazard_IF_ID_o(hz_s),
    .flush_IF_ID_o(fl_s), .bubble_ID_EX_o(bie_s), .stall_ID_EX_o(sie_s), .stall_EX_MEM_o(sem_s),
    .bubble_MEM_WB_o(bmw_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s),
    .mem_err_o(mem_err_s), .dbg_state(st_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; ex_memread = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs);
    ex_memread = 1'b1; ex_rt = rt; id_rs = rs;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RESET) begin
      failures++; $display("FAIL reset_ctl actual=%b required=%b", ctl, C_RESET);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_cnt, flush_cnt, mem_err, st} !== 67'd0) begin
      failures++; $display("FAIL reset_state stall=%0d flush=%0d err=%b st=%0d required all 0",
                           stall_cnt, flush_cnt, mem_err, st);
    end
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL idle_ctl actual=%b required=%b", ctl, C_IDLE);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd8, 5'd8);
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL lu_ctl actual=%b required=%b", ctl, C_LU);
    end
    step();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 32'd1 || ctl !== C_IDLE || st !== 2'd0) begin
      failures++; $display("FAIL lu_after stall=%0d ctl=%b st=%0d required 1 %b 0",
                           stall_cnt, ctl, st, C_IDLE);
    end
  endtask

  task automatic test_reg_gating();
    idle();
    set_lu(5'd0, 5'd0);
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL r0_no_stall actual=%b required=%b", ctl, C_IDLE);
    end
    idle();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL rt_unused_no_stall actual=%b required=%b", ctl, C_IDLE);
    end
    id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL rt_used_stall actual=%b required=%b", ctl, C_LU);
    end
    ex_memread = 1'b0;
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL no_load_no_stall actual=%b required=%b", ctl, C_IDLE);
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin
      failures++; $display("FAIL branch_ctl actual=%b required=%b", ctl, C_BRANCH);
    end
    step();
    checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL branch_cnt flush=%0d stall=%0d required 1 0", flush_cnt, stall_cnt);
    end
    set_lu(5'd12, 5'd12);
    #1;
    checks++;
    if (ctl !== C_LU) begin
      failures++; $display("FAIL branch_lu_ctl actual=%b required=%b", ctl, C_LU);
    end
    step();
    idle();
    #1;
    checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
      failures++; $display("FAIL branch_lu_cnt flush=%0d stall=%0d required 1 1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dmem_busy = 1'b1;
      set_lu(5'd4, 5'd4);
      branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin
        failures++; $display("FAIL wait_ctl cycle=%0d actual=%b required=%b", i, ctl, C_FREEZE);
      end
      step();
      checks++;
      if (st !== 2'd1) begin
        failures++; $display("FAIL wait_state cycle=%0d actual=%0d required=1", i, st);
      end
    end
    idle();
    #1;
    checks++;
    if (ctl !== C_IDLE) begin
      failures++; $display("FAIL wait_release_ctl actual=%b required=%b", ctl, C_IDLE);
    end
    step();
    checks++;
    if (st !== 2'd0 || stall_cnt !== 32'd5 || mem_err !== 1'b0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL wait_end st=%0d stall=%0d err=%b flush=%0d required 0 5 0 0",
                           st, stall_cnt, mem_err, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (st_s !== 2'd1 || mem_err_s !== 1'b0) begin
      failures++; $display("FAIL timeout_pre st=%0d err=%b required 1 0", st_s, mem_err_s);
    end
    step();
    checks++;
    if (st_s !== 2'd2 || mem_err_s !== 1'b1 || stall_cnt_s !== 3'd5) begin
      failures++; $display("FAIL timeout_halt st=%0d err=%b stall=%0d required 2 1 5",
                           st_s, mem_err_s, stall_cnt_s);
    end
    dmem_busy = 1'b0;
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl_s !== C_FREEZE || ctl !== C_BRANCH) begin
      failures++; $display("FAIL halt_freeze small=%b big=%b required %b %b",
                           ctl_s, ctl, C_FREEZE, C_BRANCH);
    end
    step();
    checks++;
    if (st_s !== 2'd2 || stall_cnt_s !== 3'd6) begin
      failures++; $display("FAIL halt_hold st=%0d stall=%0d required 2 6", st_s, stall_cnt_s);
    end
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl_s !== C_RESET) begin
      failures++; $display("FAIL halt_reset_ctl actual=%b required=%b", ctl_s, C_RESET);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (st_s !== 2'd0 || mem_err_s !== 1'b0 || stall_cnt_s !== 3'd0 || flush_cnt_s !== 3'd0) begin
      failures++; $display("FAIL halt_reset_state st=%0d err=%b stall=%0d flush=%0d required 0 0 0 0",
                           st_s, mem_err_s, stall_cnt_s, flush_cnt_s);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_lu(5'd7, 5'd7);
    for (int i = 0; i < 10; i++) step();
    idle();
    #1;
    checks++;
    if (stall_cnt_s !== 3'd7 || stall_cnt !== 32'd10) begin
      failures++; $display("FAIL saturate small=%0d big=%0d required 7 10", stall_cnt_s, stall_cnt);
    end
    dmem_busy = 1'b1;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RESET || st !== 2'd1) begin
      failures++; $display("FAIL reset_in_wait ctl=%b st=%0d required %b 1", ctl, st, C_RESET);
    end
    step();
    idle();
    #1;
    checks++;
    if (st !== 2'd0 || ctl !== C_IDLE || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL after_wait_reset st=%0d ctl=%b stall=%0d required 0 %b 0",
                           st, ctl, stall_cnt, C_IDLE);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    test_reset();
    test_load_use();
    test_reg_gating();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
